uart_tx: RTL and testbench



---
 rtl/uart_tx.sv | 103 ++++++++++
 tb/tb_uart_tx.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: one start bit, eight data bits LSB first, one stop bit.
// Tx and RFN come straight from flops, so there is no input-to-output combinational path.
module uart_tx #(
    parameter int CLK_FREQ     = 12_000_000,
    parameter int BAUD         = 9600,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Tx_EN,
    input  logic [7:0] data,
    output logic       Tx,
    output logic       RFN
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t          state_reg;
    logic [CW-1:0]   baud_cnt_reg;
    logic [2:0]      bit_idx_reg;
    logic [7:0]      shift_reg;
    logic            tx_reg;
    logic            rfn_reg;

    wire bit_done = (baud_cnt_reg == BAUD_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            baud_cnt_reg <= '0;
            bit_idx_reg  <= '0;
            shift_reg    <= '0;
            tx_reg       <= 1'b1;
            rfn_reg      <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (Tx_EN) begin
                        shift_reg    <= data;
                        tx_reg       <= 1'b0;
                        rfn_reg      <= 1'b0;
                        baud_cnt_reg <= '0;
                        bit_idx_reg  <= '0;
                        state_reg    <= START;
                    end
                end
                START: begin
                    if (bit_done) begin
                        baud_cnt_reg <= '0;
                        bit_idx_reg  <= '0;
                        tx_reg       <= shift_reg[0];
                        state_reg    <= DATA;
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end
                DATA: begin
                    // The shift register always presents the next bit at [1] when a bit ends.
                    if (bit_done) begin
                        baud_cnt_reg <= '0;
                        shift_reg    <= shift_reg >> 1;
                        if (bit_idx_reg == 3'd7) begin
                            bit_idx_reg <= '0;
                            tx_reg      <= 1'b1;
                            state_reg   <= STOP;
                        end else begin
                            bit_idx_reg <= bit_idx_reg + 1'b1;
                            tx_reg      <= shift_reg[1];
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        baud_cnt_reg <= '0;
                        rfn_reg      <= 1'b1;
                        state_reg    <= IDLE;
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    tx_reg    <= 1'b1;
                    rfn_reg   <= 1'b1;
                end
            endcase
        end
    end

    assign Tx  = tx_reg;
    assign RFN = rfn_reg;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: frame-level model compared every cycle, plus a mid-bit sampling receiver.
// Runs with a short bit period so every scenario fits in a few thousand clocks.
module tb_uart_tx;

    localparam int TB_BAUD = 9600;
    localparam int C       = 16;
    localparam int TB_CLK  = TB_BAUD * C;

    logic       clk = 1'b0;
    logic       rst;
    logic       Tx_EN;
    logic [7:0] data;
    logic       Tx;
    logic       RFN;

    int checks   = 0;
    int failures = 0;

    uart_tx #(.CLK_FREQ(TB_CLK), .BAUD(TB_BAUD)) dut (
        .clk   (clk),
        .rst   (rst),
        .Tx_EN (Tx_EN),
        .data  (data),
        .Tx    (Tx),
        .RFN   (RFN)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a frame is the 10-bit word {stop, byte, start}; after k clocks the line shows bit k/C.
    bit       m_busy = 1'b0;
    int       m_n    = 0;
    bit [9:0] m_frame = 10'h3FF;
    bit       m_tx;
    bit       m_rfn;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 1'b0;
            m_n    = 0;
        end else if (m_busy) begin
            m_n++;
            if (m_n == 10 * C) m_busy = 1'b0;
        end else if (Tx_EN) begin
            m_busy  = 1'b1;
            m_n     = 0;
            m_frame = {1'b1, data, 1'b0};
        end
    end

    always_comb begin
        m_tx  = 1'b1;
        m_rfn = !m_busy;
        if (m_busy) m_tx = m_frame[m_n / C];
    end

    always @(negedge clk) begin
        chk("cyc_tx", Tx, m_tx);
        chk("cyc_rfn", RFN, m_rfn);
    end

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        data  = b;
        Tx_EN = 1'b1;
        @(negedge clk);
        Tx_EN = 1'b0;
    endtask

    task automatic wait_rfn(output int k);
        k = 0;
        while (RFN !== 1'b1 && k < 12 * C) begin
            @(negedge clk);
            k++;
        end
        if (RFN !== 1'b1) chk("rfn_timeout", 0, 1);
    endtask

    // Receiver: find the start edge, then sample each bit at its centre.
    task automatic recv(output logic [9:0] bits);
        int w = 0;
        bits = '0;
        while (Tx !== 1'b0 && w < 20 * C) begin
            @(negedge clk);
            w++;
        end
        if (Tx !== 1'b0) chk("start_timeout", 0, 1);
        repeat (C / 2) @(negedge clk);
        bits[0] = Tx;
        for (int i = 1; i < 10; i++) begin
            repeat (C) @(negedge clk);
            bits[i] = Tx;
        end
    endtask

    task automatic check_frame(input string name, input logic [9:0] bits, input logic [7:0] b);
        chk({name, "_start"}, bits[0], 0);
        chk({name, "_byte"}, bits[8:1], b);
        chk({name, "_stop"}, bits[9], 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] bits;
        int k;
        int lows;
        int af_exp[10] = '{0, 1, 1, 1, 1, 0, 1, 0, 1, 1};
        logic [7:0] seq_bytes[4] = '{8'hFB, 8'h1D, 8'hE4, 8'h23};

        rst   = 1'b1;
        Tx_EN = 1'b0;
        data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_tx", Tx, 1);
        chk("rst_rfn", RFN, 1);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("idle_tx", Tx, 1);
        chk("idle_rfn", RFN, 1);

        // 0xAF: bit pattern, bit duration and total frame length.
        send(8'hAF);
        data = 8'h3C;
        chk("af_rfn_low", RFN, 0);
        k = 0;
        bits = '0;
        while (RFN !== 1'b1 && k < 12 * C) begin
            if (k % C == C / 2) bits[k / C] = Tx;
            @(negedge clk);
            k++;
        end
        chk("af_len", k, 160);
        for (int i = 0; i < 10; i++) chk($sformatf("af_bit%0d", i), bits[i], af_exp[i]);
        $display("frame 0xAF length=%0d bits=%b", k, bits);

        for (int i = 0; i < 4; i++) begin
            send(seq_bytes[i]);
            recv(bits);
            check_frame("seq", bits, seq_bytes[i]);
            wait_rfn(k);
            $display("frame 0x%h decoded=0x%h", seq_bytes[i], bits[8:1]);
            repeat (40) @(negedge clk);
        end

        // Mid-frame request with new data must be ignored entirely.
        send(8'hAF);
        fork
            recv(bits);
            begin
                repeat (3 * C) @(negedge clk);
                data  = 8'h00;
                Tx_EN = 1'b1;
                @(negedge clk);
                Tx_EN = 1'b0;
            end
        join
        check_frame("midreq", bits, 8'hAF);
        wait_rfn(k);
        lows = 0;
        repeat (3 * C) begin
            @(negedge clk);
            if (Tx === 1'b0) lows++;
        end
        chk("midreq_no_frame", lows, 0);
        chk("midreq_rfn", RFN, 1);
        $display("frame 0xAF with mid-frame request decoded=0x%h", bits[8:1]);

        // Tx_EN held high: frames chain with RFN high for exactly one clock each gap.
        @(negedge clk);
        data  = 8'h55;
        Tx_EN = 1'b1;
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            wait_rfn(k);
            chk("held_len", k, 160);
            @(negedge clk);
            chk("held_gap_rfn", RFN, 0);
            chk("held_start", Tx, 0);
            $display("held frame %0d length=%0d", g, k);
        end
        Tx_EN = 1'b0;
        wait_rfn(k);
        chk("held_last_len", k, 160);

        // Asynchronous reset during data bit 3 of 0xAF.
        repeat (4) @(negedge clk);
        send(8'hAF);
        repeat (4 * C + C / 2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_tx", Tx, 1);
        chk("arst_rfn", RFN, 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2 * C) @(negedge clk);
        chk("arst_no_resume", Tx, 1);
        send(8'hC3);
        recv(bits);
        check_frame("post_rst", bits, 8'hC3);
        wait_rfn(k);
        $display("frame 0xC3 after reset decoded=0x%h", bits[8:1]);

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
